alu_share_arbiter: RTL and testbench

- Shares the single 32-bit ALU between two requesters (0: instruction execute path, 1: address/auxiliary path).
- Round-robin arbitration, registered operand issue, registered result/flag capture, and a response channel with backpressure.
- Maintains the architectural NZCV flag register, updated on flag-setting operations.
- Sits between the requesters and the ALU; the ALU stays purely combinational.

---
 rtl/alu_share_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// ============================================================================
// alu_share_arbiter: round-robin 2:1 share of one combinational 32-bit ALU with NZCV flag register.
// Optional statistics counters enabled by ALU_ARB_STATS_EN.  Revision 1.0
// ============================================================================
`default_nettype none

module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [3:0]        req_cmd0,
    input  logic [1:0]        req_op0,
    input  logic              req_s0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [3:0]        req_cmd1,
    input  logic [1:0]        req_op1,
    input  logic              req_s1,
    output logic [DATA_W-1:0] alu_port_A,
    output logic [DATA_W-1:0] alu_port_B,
    output logic [3:0]        alu_cmd,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic [3:0]        rsp_flags,
    output logic [3:0]        nzcv
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  grant_cnt0,
    output logic [CNT_W-1:0]  grant_cnt1,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [1:0] C_OP_DP  = 2'b00;
    localparam logic [3:0] C_CMD_CMP = 4'b1010;

    generate
        if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
            $error("alu_share_arbiter: DATA_W and CNT_W must be positive");
        end
    endgenerate

    state_t              r_state;
    state_t              w_next_state;

    logic                r_last_grant;
    logic                w_grant;
    logic                w_accept;

    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [3:0]          r_cmd;
    logic [1:0]          r_op;
    logic                r_s;
    logic                r_id;

    logic [DATA_W-1:0]   r_rsp_data;
    logic [3:0]          r_rsp_flags;
    logic                r_rsp_id;
    logic [3:0]          r_nzcv;

    logic                w_set_flags;

    logic [DATA_W-1:0]   w_sel_a;
    logic [DATA_W-1:0]   w_sel_b;
    logic [3:0]          w_sel_cmd;
    logic [1:0]          w_sel_op;
    logic                w_sel_s;

    // Both valid: the requester that did not win last time; otherwise the lone valid one.
    always_comb begin
        w_grant = 1'b0;
        if (req_valid == 2'b11) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = req_valid[1];
        end
    end

    always_comb begin
        w_sel_a   = w_grant ? req_a1   : req_a0;
        w_sel_b   = w_grant ? req_b1   : req_b0;
        w_sel_cmd = w_grant ? req_cmd1 : req_cmd0;
        w_sel_op  = w_grant ? req_op1  : req_op0;
        w_sel_s   = w_grant ? req_s1   : req_s0;
    end

    // CMP updates flags even when the requester leaves the set-flags bit clear.
    assign w_set_flags = r_s | ((r_op == C_OP_DP) && (r_cmd == C_CMD_CMP));

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        req_ready    = 2'b00;
        rsp_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_EXEC;
                    if (w_grant) begin
                        req_ready = 2'b10;
                    end else begin
                        req_ready = 2'b01;
                    end
                end
            end
            S_EXEC: begin
                w_next_state = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_cmd        <= '0;
            r_op         <= '0;
            r_s          <= 1'b0;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_a          <= w_sel_a;
            r_b          <= w_sel_b;
            r_cmd        <= w_sel_cmd;
            r_op         <= w_sel_op;
            r_s          <= w_sel_s;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
            r_rsp_id    <= 1'b0;
            r_nzcv      <= '0;
        end else if (r_state == S_EXEC) begin
            r_rsp_data  <= alu_result;
            r_rsp_flags <= alu_flags;
            r_rsp_id    <= r_id;
            if (w_set_flags) begin
                r_nzcv <= alu_flags;
            end
        end
    end

    assign alu_port_A = r_a;
    assign alu_port_B = r_b;
    assign alu_cmd    = r_cmd;
    assign alu_op     = r_op;

    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;
    assign rsp_flags  = r_rsp_flags;
    assign nzcv       = r_nzcv;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] r_grant_cnt0;
    logic [CNT_W-1:0] r_grant_cnt1;
    logic [CNT_W-1:0] r_stall_cnt;

    // All counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant_cnt0 <= '0;
            r_grant_cnt1 <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_accept && !w_grant && (r_grant_cnt0 != {CNT_W{1'b1}})) begin
                r_grant_cnt0 <= r_grant_cnt0 + CNT_W'(1);
            end
            if (w_accept && w_grant && (r_grant_cnt1 != {CNT_W{1'b1}})) begin
                r_grant_cnt1 <= r_grant_cnt1 + CNT_W'(1);
            end
            if ((r_state == S_RESP) && !rsp_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign grant_cnt0 = r_grant_cnt0;
    assign grant_cnt1 = r_grant_cnt1;
    assign stall_cnt  = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
// ============================================================================
// tb_alu_share_arbiter: scoreboard bench for alu_share_arbiter with a behavioural ALU.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic [3:0]  req_cmd0, req_cmd1;
    logic [1:0]  req_op0, req_op1;
    logic        req_s0, req_s1;
    logic [31:0] alu_port_A, alu_port_B;
    logic [3:0]  alu_cmd;
    logic [1:0]  alu_op;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_flags;
    logic [3:0]  nzcv;
`ifdef ALU_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1, stall_cnt;
`endif

    alu_share_arbiter #(.DATA_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_cmd0(req_cmd0), .req_op0(req_op0), .req_s0(req_s0),
        .req_a1(req_a1), .req_b1(req_b1), .req_cmd1(req_cmd1), .req_op1(req_op1), .req_s1(req_s1),
        .alu_port_A(alu_port_A), .alu_port_B(alu_port_B), .alu_cmd(alu_cmd), .alu_op(alu_op),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .nzcv(nzcv)
`ifdef ALU_ARB_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural ALU: ADD, SUB, CMP in the data-processing group, everything else returns 0.
    logic [32:0] w_sum;
    always_comb begin
        w_sum      = '0;
        alu_result = '0;
        alu_flags  = '0;
        if (alu_op == 2'b00 && alu_cmd == 4'b0100) begin
            w_sum      = {1'b0, alu_port_A} + {1'b0, alu_port_B};
            alu_result = w_sum[31:0];
            alu_flags  = {w_sum[31], w_sum[31:0] == 32'd0, w_sum[32],
                          (alu_port_A[31] == alu_port_B[31]) && (w_sum[31] != alu_port_A[31])};
        end else if (alu_op == 2'b00 && (alu_cmd == 4'b0010 || alu_cmd == 4'b1010)) begin
            w_sum      = {1'b0, alu_port_A} + {1'b0, ~alu_port_B} + 33'd1;
            alu_result = w_sum[31:0];
            alu_flags  = {w_sum[31], w_sum[31:0] == 32'd0, w_sum[32],
                          (alu_port_A[31] != alu_port_B[31]) && (w_sum[31] != alu_port_A[31])};
        end
    end

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic [3:0]  flags;
        logic [3:0]  nzcv;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every completed response handshake is matched against the queue head.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rsp: got id %0d data %0h required no response", rsp_id, rsp_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_id", rsp_id, e.id);
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_flags", rsp_flags, e.flags);
                chk("nzcv", nzcv, e.nzcv);
            end
        end
    end

    // Present one request, push its expectation, return right after acceptance (DUT now in EXEC).
    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] cmd, input logic [1:0] op, input logic s,
                         input bit push, input logic [31:0] ed, input logic [3:0] ef,
                         input logic [3:0] en);
        bit got;
        exp_t e;
        got = 1'b0;
        if (id == 0) begin
            req_a0 = a; req_b0 = b; req_cmd0 = cmd; req_op0 = op; req_s0 = s;
        end else begin
            req_a1 = a; req_b1 = b; req_cmd1 = cmd; req_op1 = op; req_s1 = s;
        end
        req_valid[id] = 1'b1;
        if (push) begin
            e.id = id[0]; e.data = ed; e.flags = ef; e.nzcv = en;
            exp_q.push_back(e);
        end
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_ready[id]) got = 1'b1;
            @(posedge clk);
            #1;
        end
        req_valid[id] = 1'b0;
        chk("accept", got, 1'b1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid) done = 1'b1;
        end
        chk("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ca0 [4] = '{32'd1, 32'd10, 32'd100, 32'h1000};
    logic [31:0] cb0 [4] = '{32'd2, 32'd20, 32'd200, 32'h2000};
    logic [31:0] cr0 [4] = '{32'd3, 32'd30, 32'd300, 32'h3000};
    logic [31:0] ca1 [4] = '{32'd9, 32'd4, 32'd7, 32'h8000_0000};
    logic [31:0] cb1 [4] = '{32'd4, 32'd9, 32'd7, 32'd1};
    logic [31:0] cr1 [4] = '{32'd5, 32'hFFFF_FFFB, 32'd0, 32'h7FFF_FFFF};
    logic [3:0]  cf1 [4] = '{4'b0010, 4'b1000, 4'b0110, 4'b0011};

    initial begin
        int   i0, i1;
        logic [1:0] acc;
        exp_t e;

        rst_n = 1'b0; rsp_ready = 1'b1; req_valid = 2'b00;
        req_a0 = '0; req_b0 = '0; req_cmd0 = '0; req_op0 = '0; req_s0 = 1'b0;
        req_a1 = '0; req_b1 = '0; req_cmd1 = '0; req_op1 = '0; req_s1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_id", rsp_id, 1'b0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_flags", rsp_flags, 4'd0);
        chk("rst_nzcv", nzcv, 4'd0);
        chk("rst_alu_a", alu_port_A, 32'd0);
        chk("rst_alu_cmd", alu_cmd, 4'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single ADD with s=1; response two cycles after the accept cycle.
        issue(0, 32'd5, 32'd7, 4'b0100, 2'b00, 1'b1, 1'b1, 32'd12, 4'b0000, 4'b0000);
        @(negedge clk);
        chk("lat_exec_no_valid", rsp_valid, 1'b0);
        chk("exec_alu_a", alu_port_A, 32'd5);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_resp_valid", rsp_valid, 1'b1);
        drain();

        // CMP without s still updates flags; following ADD without s leaves them.
        issue(1, 32'd3, 32'd3, 4'b1010, 2'b00, 1'b0, 1'b1, 32'd0, 4'b0110, 4'b0110);
        drain();
        issue(0, 32'h7FFF_FFFF, 32'd1, 4'b0100, 2'b00, 1'b0, 1'b1, 32'h8000_0000, 4'b1001, 4'b0110);
        drain();

        // Backpressure: five stalled RESP cycles with requester 1 waiting.
        rsp_ready = 1'b0;
        issue(0, 32'h10, 32'h20, 4'b0010, 2'b00, 1'b0, 1'b1, 32'hFFFF_FFF0, 4'b1000, 4'b0110);
        @(posedge clk); #1;
        req_a1 = 32'd1; req_b1 = 32'd1; req_cmd1 = 4'b0100; req_op1 = 2'b00; req_s1 = 1'b0;
        req_valid[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_rsp_valid", rsp_valid, 1'b1);
            chk("bp_rsp_data", rsp_data, 32'hFFFF_FFF0);
            chk("bp_req_ready", req_ready, 2'b00);
            @(posedge clk); #1;
        end
        req_valid[1] = 1'b0;
        rsp_ready = 1'b1;
        drain();
`ifdef ALU_ARB_STATS_EN
        chk("stat_grant0", grant_cnt0, 16'd3);
        chk("stat_grant1", grant_cnt1, 16'd1);
        chk("stat_stall", stall_cnt, 16'd5);
`endif

        // Reset while the operation sits in EXEC: nothing comes out, flags clear.
        issue(0, 32'hFFFF_FFFF, 32'd1, 4'b0100, 2'b00, 1'b1, 1'b0, 32'd0, 4'd0, 4'd0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_nzcv", nzcv, 4'd0);
        chk("midrst_alu_a", alu_port_A, 32'd0);
        chk("midrst_req_ready", req_ready, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("midrst_no_rsp", rsp_valid, 1'b0);
            @(posedge clk); #1;
        end

        // Contention: both requesters busy, grants must alternate starting with requester 0.
        for (int k = 0; k < 4; k++) begin
            e.id = 1'b0; e.data = cr0[k]; e.flags = 4'b0000; e.nzcv = 4'b0000;
            exp_q.push_back(e);
            e.id = 1'b1; e.data = cr1[k]; e.flags = cf1[k]; e.nzcv = (k == 3) ? 4'b0011 : 4'b0000;
            exp_q.push_back(e);
        end
        i0 = 0; i1 = 0;
        for (int k = 0; k < 100 && (i0 < 4 || i1 < 4); k++) begin
            req_valid[0] = (i0 < 4);
            if (i0 < 4) begin
                req_a0 = ca0[i0]; req_b0 = cb0[i0]; req_cmd0 = 4'b0100; req_op0 = 2'b00; req_s0 = 1'b0;
            end
            req_valid[1] = (i1 < 4);
            if (i1 < 4) begin
                req_a1 = ca1[i1]; req_b1 = cb1[i1]; req_cmd1 = 4'b0010; req_op1 = 2'b00;
                req_s1 = (i1 == 3);
            end
            @(negedge clk);
            chk("ready_onehot", $countones(req_ready) <= 1, 1'b1);
            acc = req_ready & req_valid;
            @(posedge clk); #1;
            if (acc[0]) i0++;
            if (acc[1]) i1++;
        end
        req_valid = 2'b00;
        chk("contention_done", i0 + i1, 8);
        drain();
`ifdef ALU_ARB_STATS_EN
        chk("stat_grant0_c", grant_cnt0, 16'd4);
        chk("stat_grant1_c", grant_cnt1, 16'd4);
        chk("stat_stall_c", stall_cnt, 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end required end");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
